// File: rtl/eff_pkg.sv
// Shared constants and types for the tap-tempo block.
package eff_pkg;

  // Default width of the delay length, in samples.
  localparam int DLY_WIDTH_DEF = 16;

  // Tap measurement state machine.
  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } tap_state_e;

endpackage

// File: rtl/tap_debounce.sv
// Footswitch conditioning: a 2-flop synchronizer followed by a level debouncer.
// o_tap_evt pulses for one clk when the debounced level rises.
module tap_debounce
  import eff_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tap,
  output logic o_tap_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       r_sync;
  logic             r_deb;
  logic [CNT_W-1:0] r_cnt;
  logic             r_evt;

  // Bring the raw footswitch level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_tap};
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYC consecutive clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_deb <= 1'b0;
      r_cnt <= '0;
      r_evt <= 1'b0;
    end else begin
      r_evt <= 1'b0;
      if (r_sync[1] != r_deb) begin
        if (r_cnt == CNT_LAST) begin
          r_deb <= r_sync[1];
          r_cnt <= '0;
          r_evt <= r_sync[1];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_tap_evt = r_evt;

endmodule

// File: rtl/eff_tap_tempo.sv
// Tap-tempo controller: measures the sample count between footswitch taps and
// publishes it as a delay length, with a beat LED running at that period.
// Build option: define EFF_TAP_TEMPO_AVG_EN to average each accepted interval
// with the current delay instead of replacing it.
module eff_tap_tempo
  import eff_pkg::*;
#(
  parameter int DLY_WIDTH    = DLY_WIDTH_DEF,
  parameter int DEFAULT_DLY  = 12000,
  parameter int MIN_DLY      = 256,
  parameter int MAX_DLY      = 48000,
  parameter int DEBOUNCE_CYC = 1000,
  parameter int LED_LEN      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 tap_i,
  input  logic                 vld_i,
  output logic [DLY_WIDTH-1:0] delay_o,
  output logic                 delay_vld_o,
  output logic                 led_o
);

  // One extra bit so the interval counter can hold MAX_DLY+1 (the timeout mark).
  localparam int CNT_W = DLY_WIDTH + 1;
  localparam logic [CNT_W-1:0]     C_MIN   = CNT_W'(MIN_DLY);
  localparam logic [CNT_W-1:0]     C_MAX   = CNT_W'(MAX_DLY);
  localparam logic [DLY_WIDTH-1:0] C_DEF   = DLY_WIDTH'(DEFAULT_DLY);
  localparam logic [DLY_WIDTH-1:0] C_LED   = DLY_WIDTH'(LED_LEN);
  localparam logic [DLY_WIDTH-1:0] C_MAX_D = DLY_WIDTH'(MAX_DLY);

  logic                 w_tap_evt;
  tap_state_e           r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [DLY_WIDTH-1:0] r_dly, w_dly_next, w_new_dly;
  logic                 r_dly_vld, w_dly_vld_next;
  logic [DLY_WIDTH-1:0] r_beat, w_beat_next;
  logic                 r_led;
  logic                 r_en_d;

  tap_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_tap_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_tap    (tap_i),
    .o_tap_evt(w_tap_evt)
  );

`ifdef EFF_TAP_TEMPO_AVG_EN
  logic [DLY_WIDTH:0]   w_sum;
  logic [DLY_WIDTH-1:0] w_avg;
  assign w_sum = {1'b0, r_dly} + {1'b0, r_cnt[DLY_WIDTH-1:0]};
  assign w_avg = DLY_WIDTH'(w_sum >> 1);
  // Averaging against an out-of-range reset default could exceed MAX_DLY; clamp it.
  assign w_new_dly = (w_avg > C_MAX_D) ? C_MAX_D : w_avg;
`else
  assign w_new_dly = r_cnt[DLY_WIDTH-1:0];
`endif

  // Measurement FSM next-state: taps start/close intervals, overlong intervals time out.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_dly_next     = r_dly;
    w_dly_vld_next = 1'b0;
    if (!en) begin
      w_state_next = IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tap_evt) begin
            w_state_next = MEASURE;
            w_cnt_next   = '0;
          end
        end
        MEASURE: begin
          if (r_cnt > C_MAX) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else if (w_tap_evt && (r_cnt >= C_MIN)) begin
            // A coincident sample strobe is dropped: the new interval starts at 0.
            w_dly_next     = w_new_dly;
            w_dly_vld_next = 1'b1;
            w_cnt_next     = '0;
          end else if (vld_i) begin
            // Timeout fires at MAX_DLY+1, so this increment saturates there.
            w_cnt_next = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  // Measurement FSM registers and the published delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_dly     <= C_DEF;
      r_dly_vld <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_dly     <= w_dly_next;
      r_dly_vld <= w_dly_vld_next;
    end
  end

  // Beat phase: samples modulo delay, re-aligned on every new delay and on enable.
  always_comb begin
    w_beat_next = r_beat;
    if (!en || !r_en_d || r_dly_vld) begin
      w_beat_next = '0;
    end else if (vld_i) begin
      w_beat_next = (r_beat >= r_dly - 1'b1) ? '0 : r_beat + 1'b1;
    end
  end

  // Beat counter, LED level and enable history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
      r_led  <= 1'b0;
      r_en_d <= 1'b0;
    end else begin
      r_beat <= w_beat_next;
      r_led  <= en && (w_beat_next < C_LED);
      r_en_d <= en;
    end
  end

  assign delay_o     = r_dly;
  assign delay_vld_o = r_dly_vld;
  assign led_o       = r_led & en;

endmodule

// File: doc/eff_tap_tempo.md
EFF_TAP_TEMPO -- requirements
Module: eff_tap_tempo

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DLY_WIDTH, 16, width of delay length in samples.
- DEFAULT_DLY, 12000, delay_o value after reset.
- MIN_DLY, 256, shortest accepted tap interval in samples.
- MAX_DLY, 48000, longest accepted interval; also the measurement timeout.
- DEBOUNCE_CYC, 1000, clk cycles tap level must be stable.
- LED_LEN, 64, samples led_o stays high per beat.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock.
- rst_n, input, 1, asynchronous active-low reset.
- en, input, 1, block enable.
- tap_i, input, 1, raw asynchronous footswitch level.
- vld_i, input, 1, one-clk sample strobe; the time base.
- delay_o, output, DLY_WIDTH, delay length for the delay effect.
- delay_vld_o, output, 1, one-clk pulse when delay_o changes.
- led_o, output, 1, beat indicator.

Function
REQ-003 tap_i SHALL pass a 2-flop synchronizer; the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYC consecutive clk; a debounced rising edge SHALL produce a one-clk tap event.
REQ-004 FSM states SHALL be IDLE and MEASURE; reset state IDLE.
REQ-005 IDLE: tap event -> MEASURE with sample count cleared to 0.
REQ-006 MEASURE: count SHALL increment by 1 on each vld_i; count SHALL saturate at MAX_DLY+1.
REQ-007 MEASURE, tap event with MIN_DLY <= count <= MAX_DLY: delay_o SHALL update on the next clk, delay_vld_o SHALL pulse that same cycle, count SHALL restart at 0, state stays MEASURE.
REQ-008 MEASURE, tap event with count < MIN_DLY: the tap SHALL be ignored (no update, count continues).
REQ-009 MEASURE, count > MAX_DLY: -> IDLE with no delay_o update.
REQ-010 Tap event and vld_i in the same cycle: the tap SHALL be evaluated against the pre-increment count, and that vld_i SHALL NOT be counted in the new interval.
REQ-011 Beat counter: SHALL count vld_i modulo delay_o; led_o SHALL be high while beat count < LED_LEN; the beat counter SHALL restart at 0 on every delay_vld_o.
REQ-012 en low: FSM SHALL be forced to IDLE, tap events ignored, delay_o held, delay_vld_o=0, led_o=0; on en rising, the beat counter SHALL restart at 0.
REQ-013 delay_o SHALL never leave [MIN_DLY, MAX_DLY] except the DEFAULT_DLY reset value.

Reset
REQ-014 rst_n low SHALL asynchronously set: delay_o=DEFAULT_DLY, delay_vld_o=0, led_o=0, state IDLE, all counters 0, debounced level 0, synchronizer flops 0.
REQ-015 Reset asserted mid-MEASURE SHALL discard the partial interval; the first tap after release SHALL start a fresh measurement.

Configuration
REQ-016 Macro EFF_TAP_TEMPO_AVG_EN defined: an accepted interval SHALL set delay_o=(delay_o+count)>>1, computed at DLY_WIDTH+1 bits and truncated.
REQ-017 Macro EFF_TAP_TEMPO_AVG_EN undefined: an accepted interval SHALL set delay_o=count; no averaging logic is present.

Structure
REQ-018 Package eff_pkg SHALL hold the DLY_WIDTH default constant and the tap FSM state enum (IDLE, MEASURE).
REQ-019 The synchronizer plus debouncer SHALL be sub-module tap_debounce, which outputs the tap event pulse.

Verification
Bench setup: DEBOUNCE_CYC=4, MIN_DLY=16, MAX_DLY=1000, LED_LEN=4, vld_i every 8 clk, macro undefined unless stated.
REQ-020 Clean taps 100 samples apart -> delay_o=100, exactly one delay_vld_o pulse; led_o high 4 samples of every 100.
REQ-021 Taps at samples 0, 10, 120 -> the tap at 10 is ignored; delay_o=120.
REQ-022 One tap, then 1001 samples with no tap -> IDLE, delay_o unchanged, no delay_vld_o.
REQ-023 tap_i high for 2 clk only -> no tap event, no state change.
REQ-024 EFF_TAP_TEMPO_AVG_EN defined, delay_o=100, next interval 200 -> delay_o=150 (200 when the macro is undefined).
REQ-025 rst_n low mid-MEASURE, and en low for 70 clk -> delay_o=12000 after reset; during en low led_o=0 and taps are ignored.
